// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction handshake, ALU port and retire outputs of alu_issue_ctrl.
// The slave modport is the controller's view; master is the surrounding pipeline/ALU.
interface alu_issue_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [1:0]       in_cond;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [RA_W-1:0]  in_dest;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic [1:0]       opSel;
    logic [WIDTH-1:0] aluOut;
    logic             aluCarry;
    logic             wr_en;
    logic [RA_W-1:0]  wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             eq_valid;
    logic             eq_out;
    logic             done;
    logic             c_flag;
    logic             z_flag;

    modport slave (
        input  in_valid, in_op, in_cond, in_a, in_b, in_dest, aluOut, aluCarry,
        output in_ready, aluA, aluB, opSel, wr_en, wr_addr, wr_data,
               eq_valid, eq_out, done, c_flag, z_flag
    );

    modport master (
        output in_valid, in_op, in_cond, in_a, in_b, in_dest, aluOut, aluCarry,
        input  in_ready, aluA, aluB, opSel, wr_en, wr_addr, wr_data,
               eq_valid, eq_out, done, c_flag, z_flag
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: accepts one instruction, drives the external ALU for a cycle,
// captures the result and retires it as a writeback or compare strobe, owning the C/Z flags.
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 3
) (
    input logic             clk,
    input logic             reset,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_RETIRE  = 2'd3;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_CMP  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [RA_W-1:0]  dest_q, dest_d;
    logic             skip_q, skip_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             res_zero_q, res_zero_d;
    logic             c_q, c_d, z_q, z_d;
    logic             wr_en_q, wr_en_d;
    logic [RA_W-1:0]  wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             eq_valid_q, eq_valid_d;
    logic             eq_out_q, eq_out_d;
    logic             done_q, done_d;
    logic             cond_ok;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        dest_d     = dest_q;
        skip_d     = skip_q;
        res_d      = res_q;
        carry_d    = carry_q;
        res_zero_d = res_zero_q;
        c_d        = c_q;
        z_d        = z_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        eq_out_d   = eq_out_q;
        wr_en_d    = 1'b0;
        eq_valid_d = 1'b0;
        done_d     = 1'b0;
        cond_ok    = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d   = bus.in_op;
                    a_d    = bus.in_a;
                    b_d    = bus.in_b;
                    dest_d = bus.in_dest;
                    case (bus.in_cond)
                        2'b10:   cond_ok = c_q;
                        2'b01:   cond_ok = z_q;
                        default: cond_ok = 1'b1;
                    endcase
                    // Retire strobes are registered, so they are set on the edge entering RETIRE.
                    if (cond_ok && (bus.in_op != OP_NOP)) begin
                        state_d = S_ISSUE;
                        skip_d  = 1'b0;
                    end else begin
                        state_d = S_RETIRE;
                        skip_d  = 1'b1;
                        done_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                res_d   = bus.aluOut;
                carry_d = bus.aluCarry;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                res_zero_d = (res_q == '0);
                done_d     = 1'b1;
                state_d    = S_RETIRE;
                case (op_q)
                    OP_ADD, OP_NAND: begin
                        wr_en_d   = 1'b1;
                        wr_data_d = res_q;
                        wr_addr_d = dest_q;
                    end
                    OP_CMP: begin
                        eq_valid_d = 1'b1;
                        eq_out_d   = (a_q == b_q);
                    end
                    default: ;
                endcase
            end
            S_RETIRE: begin
                state_d = S_IDLE;
                if (!skip_q) begin
                    if (op_q == OP_ADD) begin
                        c_d = carry_q;
                        z_d = res_zero_q;
                    end else if (op_q == OP_NAND) begin
                        z_d = res_zero_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            dest_q     <= '0;
            skip_q     <= 1'b0;
            res_q      <= '0;
            carry_q    <= 1'b0;
            res_zero_q <= 1'b0;
            c_q        <= 1'b0;
            z_q        <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            eq_valid_q <= 1'b0;
            eq_out_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            dest_q     <= dest_d;
            skip_q     <= skip_d;
            res_q      <= res_d;
            carry_q    <= carry_d;
            res_zero_q <= res_zero_d;
            c_q        <= c_d;
            z_q        <= z_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            eq_valid_q <= eq_valid_d;
            eq_out_q   <= eq_out_d;
            done_q     <= done_d;
        end
    end

    assign bus.in_ready = (state_q == S_IDLE);
    assign bus.opSel    = (state_q == S_ISSUE) ? op_q : OP_NOP;
    assign bus.aluA     = a_q;
    assign bus.aluB     = b_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.eq_valid = eq_valid_q;
    assign bus.eq_out   = eq_out_q;
    assign bus.done     = done_q;
    assign bus.c_flag   = c_q;
    assign bus.z_flag   = z_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: transaction-level model predicts retire events per cycle,
// plus directed literal checks of the retired results and flags.
module tb_alu_issue_ctrl;
    localparam int WIDTH = 16;
    localparam int RA_W  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    alu_issue_ctrl_if #(.WIDTH(WIDTH), .RA_W(RA_W)) bus ();

    alu_issue_ctrl #(.WIDTH(WIDTH), .RA_W(RA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural ALU: add, xor for compare (unused by the controller), nand.
    logic [WIDTH:0] alu_sum;
    assign alu_sum = {1'b0, bus.aluA} + {1'b0, bus.aluB};
    always_comb begin
        case (bus.opSel)
            2'b01:   bus.aluOut = alu_sum[WIDTH-1:0];
            2'b10:   bus.aluOut = bus.aluA ^ bus.aluB;
            2'b11:   bus.aluOut = ~(bus.aluA & bus.aluB);
            default: bus.aluOut = '0;
        endcase
        bus.aluCarry = (bus.opSel == 2'b01) ? alu_sum[WIDTH] : 1'b0;
    end

    typedef struct {
        int               cyc;
        bit               wr;
        bit               eqv;
        bit               eqo;
        logic [WIDTH-1:0] data;
        logic [RA_W-1:0]  addr;
        bit               c;
        bit               z;
    } exp_t;

    exp_t             q[$];
    int               acc_cyc[$];
    int               cyc = 0;
    int               n_vec = 0;
    int               n_err = 0;
    int               acc_count = 0;
    int               iss_cyc = -10;
    logic [1:0]       iss_op;
    logic [WIDTH-1:0] iss_a, iss_b;
    bit               mc = 1'b0, mz = 1'b0;
    bit               armed = 1'b0;
    logic [WIDTH-1:0] last_wr_data = '0;
    bit               last_eq_out = 1'b0;
    int               wr_cnt = 0, eqv_cnt = 0, done_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare against the model, then model update for this cycle.
    always @(negedge clk) begin
        automatic bit   busy = (q.size() != 0);
        automatic bit   hit = 1'b0;
        automatic exp_t e;
        automatic exp_t n;
        automatic bit   skip;
        automatic logic [WIDTH:0] s;
        if (armed) begin
            if (busy && q[0].cyc == cyc) begin
                hit = 1'b1;
                e = q[0];
            end
            chk("in_ready", bus.in_ready, !busy);
            chk("opSel", bus.opSel, (cyc == iss_cyc) ? iss_op : 2'b00);
            if (cyc == iss_cyc || cyc == iss_cyc + 1) begin
                chk("aluA", bus.aluA, iss_a);
                chk("aluB", bus.aluB, iss_b);
            end
            chk("wr_en", bus.wr_en, hit && e.wr);
            chk("eq_valid", bus.eq_valid, hit && e.eqv);
            chk("done", bus.done, hit);
            chk("c_flag", bus.c_flag, mc);
            chk("z_flag", bus.z_flag, mz);
            if (hit && e.wr) begin
                chk("wr_addr", bus.wr_addr, e.addr);
                chk("wr_data", bus.wr_data, e.data);
            end
            if (hit && e.eqv) chk("eq_out", bus.eq_out, e.eqo);
            if (bus.wr_en === 1'b1) begin
                last_wr_data = bus.wr_data;
                wr_cnt++;
            end
            if (bus.eq_valid === 1'b1) begin
                last_eq_out = bus.eq_out;
                eqv_cnt++;
            end
            if (bus.done === 1'b1) done_cnt++;
            if (hit) begin
                mc = e.c;
                mz = e.z;
                void'(q.pop_front());
            end
        end
        if (reset) begin
            q.delete();
            mc = 1'b0;
            mz = 1'b0;
            iss_cyc = -10;
            armed = 1'b1;
        end else if (armed && bus.in_valid && !busy) begin
            skip = (bus.in_op == 2'b00) || (bus.in_cond == 2'b10 && !mc) ||
                   (bus.in_cond == 2'b01 && !mz);
            n.cyc  = skip ? cyc + 1 : cyc + 3;
            n.wr   = !skip && (bus.in_op == 2'b01 || bus.in_op == 2'b11);
            n.eqv  = !skip && (bus.in_op == 2'b10);
            n.eqo  = (bus.in_a == bus.in_b);
            n.addr = bus.in_dest;
            n.data = '0;
            n.c    = mc;
            n.z    = mz;
            if (!skip && bus.in_op == 2'b01) begin
                s = {1'b0, bus.in_a} + {1'b0, bus.in_b};
                n.data = s[WIDTH-1:0];
                n.c    = s[WIDTH];
                n.z    = (n.data == 0);
            end else if (!skip && bus.in_op == 2'b11) begin
                n.data = ~(bus.in_a & bus.in_b);
                n.z    = (n.data == 0);
            end
            if (!skip) begin
                iss_cyc = cyc + 1;
                iss_op  = bus.in_op;
                iss_a   = bus.in_a;
                iss_b   = bus.in_b;
            end
            q.push_back(n);
            acc_cyc.push_back(cyc);
            acc_count++;
        end
    end

    task automatic send(input logic [1:0] op, input logic [1:0] cond,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [RA_W-1:0] dest);
        int start;
        start = acc_count;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_cond  = cond;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_dest  = dest;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (acc_count != start) break;
        end
        if (acc_count == start) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle_wait();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    initial begin
        int w0, d0, e0, base;
        bus.in_valid = 1'b0;
        bus.in_op    = '0;
        bus.in_cond  = '0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_dest  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_flags", {bus.c_flag, bus.z_flag}, 2'b00);
        chk("rst_alu", {bus.opSel, bus.aluA, bus.aluB}, 0);
        @(posedge clk);
        #1;

        send(2'b01, 2'b00, 16'd25, 16'd40, 3'd3);
        idle_wait();
        chk("lit_add_data", last_wr_data, 16'd65);
        chk("lit_add_cz", {bus.c_flag, bus.z_flag}, 2'b00);
        chk("lit_add_cnt", {wr_cnt[7:0], done_cnt[7:0]}, {8'd1, 8'd1});

        send(2'b01, 2'b00, 16'hFFFF, 16'h0001, 3'd1);
        idle_wait();
        chk("lit_wrap_data", last_wr_data, 16'h0000);
        chk("lit_wrap_cz", {bus.c_flag, bus.z_flag}, 2'b11);
        chk("lit_model_cz", {mc, mz}, 2'b11);

        send(2'b01, 2'b10, 16'd2, 16'd3, 3'd2);
        idle_wait();
        chk("lit_condc_data", last_wr_data, 16'd5);
        chk("lit_condc_cz", {bus.c_flag, bus.z_flag}, 2'b00);

        w0 = wr_cnt; d0 = done_cnt;
        send(2'b01, 2'b10, 16'd7, 16'd7, 3'd4);
        idle_wait();
        send(2'b00, 2'b00, 16'd1, 16'd2, 3'd5);
        idle_wait();
        chk("lit_skip_nowr", wr_cnt - w0, 0);
        chk("lit_skip_done", done_cnt - d0, 2);

        send(2'b01, 2'b00, 16'hFFFF, 16'h0002, 3'd6);
        idle_wait();
        chk("lit_c_set", {bus.c_flag, bus.z_flag, last_wr_data}, {2'b10, 16'h0001});
        send(2'b11, 2'b00, 16'hFFFF, 16'hFFFF, 3'd7);
        idle_wait();
        chk("lit_nand0", {bus.c_flag, bus.z_flag, last_wr_data}, {2'b11, 16'h0000});
        send(2'b11, 2'b01, 16'h00F0, 16'h0FF0, 3'd2);
        idle_wait();
        chk("lit_nand1", {bus.c_flag, bus.z_flag, last_wr_data}, {2'b10, 16'hFF0F});

        w0 = wr_cnt; e0 = eqv_cnt;
        send(2'b10, 2'b00, 16'd25, 16'd25, 3'd1);
        idle_wait();
        chk("lit_cmp_eq", last_eq_out, 1);
        send(2'b10, 2'b00, 16'd25, 16'd40, 3'd1);
        idle_wait();
        chk("lit_cmp_ne", last_eq_out, 0);
        chk("lit_cmp_cnt", {wr_cnt - w0, eqv_cnt - e0}, {32'd0, 32'd2});
        chk("lit_cmp_flags", {bus.c_flag, bus.z_flag}, 2'b10);

        base = acc_cyc.size();
        send(2'b01, 2'b00, 16'd1, 16'd1, 3'd1);
        send(2'b01, 2'b00, 16'd2, 16'd2, 3'd2);
        send(2'b01, 2'b00, 16'd3, 16'd3, 3'd3);
        idle_wait();
        chk("lit_tput_n", acc_cyc.size() - base, 3);
        chk("lit_tput_gap1", acc_cyc[base+1] - acc_cyc[base], 4);
        chk("lit_tput_gap2", acc_cyc[base+2] - acc_cyc[base+1], 4);
        chk("lit_tput_data", last_wr_data, 16'd6);

        send(2'b01, 2'b00, 16'hFFFF, 16'h0001, 3'd4);
        idle_wait();
        chk("lit_pre_rst", {bus.c_flag, bus.z_flag}, 2'b11);
        w0 = wr_cnt; d0 = done_cnt;
        send(2'b01, 2'b00, 16'd100, 16'd200, 3'd6);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("lit_rst_ready", bus.in_ready, 1);
        chk("lit_rst_flags", {bus.c_flag, bus.z_flag}, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        chk("lit_rst_abort", {wr_cnt - w0, done_cnt - d0}, 64'd0);
        send(2'b01, 2'b00, 16'd3, 16'd4, 3'd1);
        idle_wait();
        chk("lit_after_rst", last_wr_data, 16'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule
